// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit with
// bubble-collapsing valid/ready flow control. Rotate, logical and arithmetic modes.
module pipelined_barrel_shifter #(
    parameter int  DATA_WIDTH = 8,
    localparam int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_WIDTH-1:0]  in_amt,
    input  logic                  in_dir,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    if ((DATA_WIDTH < 4) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
        $error("pipelined_barrel_shifter: DATA_WIDTH must be a power of two and >= 4");
    end

    localparam logic [1:0] MODE_LOGICAL = 2'b01;
    localparam logic [1:0] MODE_ARITH   = 2'b10;

    // Right shifts take the low half of a double-width shift, left shifts the high half;
    // the upper/lower filler word selects rotate, zero fill or sign fill.
    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [DATA_WIDTH-1:0] d,
        input int unsigned           step,
        input logic                  dir_i,
        input logic [1:0]            mode_i,
        input logic                  sign_i
    );
        logic [2*DATA_WIDTH-1:0] wide;
        logic [DATA_WIDTH-1:0]   res;
        wide = '0;
        res  = '0;
        if (dir_i) begin
            case (mode_i)
                MODE_LOGICAL: wide = {{DATA_WIDTH{1'b0}}, d};
                MODE_ARITH:   wide = {{DATA_WIDTH{sign_i}}, d};
                default:      wide = {d, d};
            endcase
            wide = wide >> step;
            res  = wide[DATA_WIDTH-1:0];
        end else begin
            case (mode_i)
                MODE_LOGICAL, MODE_ARITH: wide = {d, {DATA_WIDTH{1'b0}}};
                default:                  wide = {d, d};
            endcase
            wide = wide << step;
            res  = wide[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        return res;
    endfunction

    logic [AMT_WIDTH-1:0]  valid_q, valid_d, load_s;
    logic [DATA_WIDTH-1:0] data_q [AMT_WIDTH];
    logic [DATA_WIDTH-1:0] data_d [AMT_WIDTH];
    logic [AMT_WIDTH-1:0]  amt_q  [AMT_WIDTH];
    logic [AMT_WIDTH-1:0]  amt_d  [AMT_WIDTH];
    logic [1:0]            mode_q [AMT_WIDTH];
    logic [1:0]            mode_d [AMT_WIDTH];
    logic                  dir_q  [AMT_WIDTH];
    logic                  dir_d  [AMT_WIDTH];
    logic                  sign_q [AMT_WIDTH];
    logic                  sign_d [AMT_WIDTH];

    // Load chain: a stage advances when it is empty or its successor advances.
    always_comb begin
        logic nxt_load;
        load_s   = '0;
        nxt_load = out_ready;
        for (int k = AMT_WIDTH - 1; k >= 0; k--) begin
            load_s[k] = !valid_q[k] || nxt_load;
            nxt_load  = load_s[k];
        end
    end

    // Next-state for every stage; payload only moves with a valid transaction.
    always_comb begin
        logic [DATA_WIDTH-1:0] prev_data;
        logic [AMT_WIDTH-1:0]  prev_amt;
        logic [1:0]            prev_mode;
        logic                  prev_dir, prev_sign, prev_valid;
        valid_d    = valid_q;
        data_d     = data_q;
        amt_d      = amt_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        sign_d     = sign_q;
        prev_data  = in_data;
        prev_amt   = in_amt;
        prev_mode  = in_mode;
        prev_dir   = in_dir;
        prev_sign  = in_data[DATA_WIDTH-1];
        prev_valid = in_valid;
        for (int k = 0; k < AMT_WIDTH; k++) begin
            if (load_s[k]) begin
                valid_d[k] = prev_valid;
                if (prev_valid) begin
                    data_d[k] = prev_amt[k]
                              ? shift_step(prev_data, 32'd1 << k, prev_dir, prev_mode, prev_sign)
                              : prev_data;
                    amt_d[k]  = prev_amt;
                    mode_d[k] = prev_mode;
                    dir_d[k]  = prev_dir;
                    sign_d[k] = prev_sign;
                end else begin
                    data_d[k] = data_q[k];
                end
            end else begin
                valid_d[k] = valid_q[k];
            end
            prev_data  = data_q[k];
            prev_amt   = amt_q[k];
            prev_mode  = mode_q[k];
            prev_dir   = dir_q[k];
            prev_sign  = sign_q[k];
            prev_valid = valid_q[k];
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < AMT_WIDTH; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= 2'b00;
                dir_q[k]  <= 1'b0;
                sign_q[k] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = load_s[0];
    assign out_valid = valid_q[AMT_WIDTH-1];
    assign out_data  = data_q[AMT_WIDTH-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: 8-bit instance for flow control
// and modes, 32-bit instance for the wide arithmetic/reserved-mode vectors.
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_dir, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic [2:0]  in_amt;
    logic [1:0]  in_mode;

    logic        w_in_valid, w_in_ready, w_in_dir, w_out_valid, w_out_ready;
    logic [31:0] w_in_data, w_out_data;
    logic [4:0]  w_in_amt;
    logic [1:0]  w_in_mode;

    int total = 0;
    int bad   = 0;

    logic [7:0] stream_exp [8];
    int         in_idx, out_idx, occ;
    logic       fire_in, fire_out, was_stalled, saw_block;
    logic [7:0] held_d;

    pipelined_barrel_shifter #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipelined_barrel_shifter #(.DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_amt(w_in_amt), .in_dir(w_in_dir), .in_mode(w_in_mode),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic [2:0] a,
                          input logic dr, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_mode  = m;
    endtask

    initial begin
        stream_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
        reset_n     = 1'b0;
        out_ready   = 1'b1;
        w_out_ready = 1'b1;
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        w_in_valid = 1'b0; w_in_data = 32'h0; w_in_amt = 5'd0; w_in_dir = 1'b0; w_in_mode = 2'b00;

        // reset state
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst32_out_valid", {31'd0, w_out_valid}, 32'd0);
        chk("rst32_out_data", w_out_data, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // rotate right B1 by 3, latency 3
        drive8(1'b1, 8'hB1, 3'd3, 1'b1, 2'b00);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("rot_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rot_lat2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rot_valid", {31'd0, out_valid}, 32'd1);
        chk("rot_data", {24'd0, out_data}, 32'h36);
        tick();
        chk("rot_done", {31'd0, out_valid}, 32'd0);

        // logical / arithmetic back-to-back
        drive8(1'b1, 8'h96, 3'd2, 1'b1, 2'b01);
        tick();
        drive8(1'b1, 8'h96, 3'd2, 1'b1, 2'b10);
        tick();
        drive8(1'b1, 8'h96, 3'd2, 1'b0, 2'b10);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("lsr_valid", {31'd0, out_valid}, 32'd1);
        chk("lsr_data", {24'd0, out_data}, 32'h25);
        tick();
        chk("asr_valid", {31'd0, out_valid}, 32'd1);
        chk("asr_data", {24'd0, out_data}, 32'hE5);
        tick();
        chk("asl_valid", {31'd0, out_valid}, 32'd1);
        chk("asl_data", {24'd0, out_data}, 32'h58);
        tick();
        chk("b2b_done", {31'd0, out_valid}, 32'd0);

        // stream 8 operands, consumer stalls 5 cycles from cycle 4
        in_idx = 0; out_idx = 0; occ = 0; was_stalled = 1'b0; saw_block = 1'b0; held_d = 8'h00;
        for (int c = 0; c < 60 && out_idx < 8; c++) begin
            out_ready = !(c >= 4 && c < 9);
            if (in_idx < 8) drive8(1'b1, 8'h81, 3'(in_idx), 1'b0, 2'b00);
            else            drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, {31'd0, !(occ == 3 && !out_ready)});
            if (!in_ready) saw_block = 1'b1;
            if (was_stalled) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold", {24'd0, out_data}, {24'd0, held_d});
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk("stream_order", {24'd0, out_data}, {24'd0, stream_exp[out_idx]});
                out_idx++;
            end
            was_stalled = out_valid && !out_ready;
            held_d      = out_data;
            if (fire_in) in_idx++;
            occ = occ + (fire_in ? 1 : 0) - (fire_out ? 1 : 0);
            tick();
        end
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("stream_count", out_idx, 32'd8);
        chk("stream_backpressure", {31'd0, saw_block}, 32'd1);
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // bubble collapse with consumer stalled
        out_ready = 1'b0;
        drive8(1'b1, 8'h96, 3'd2, 1'b1, 2'b01);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("bub_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bub_ready2", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bub_head_valid", {31'd0, out_valid}, 32'd1);
        chk("bub_head_data", {24'd0, out_data}, 32'h25);
        drive8(1'b1, 8'h96, 3'd2, 1'b1, 2'b10);
        #1;
        chk("bub_ready3", {31'd0, in_ready}, 32'd1);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        tick(); tick();
        chk("bub_hold_data", {24'd0, out_data}, 32'h25);
        chk("bub_ready4", {31'd0, in_ready}, 32'd1);
        drive8(1'b1, 8'h96, 3'd2, 1'b0, 2'b10);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("bub_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bub_unblock", {31'd0, in_ready}, 32'd1);
        chk("bub_out1", {24'd0, out_data}, 32'h25);
        tick();
        chk("bub_out2_valid", {31'd0, out_valid}, 32'd1);
        chk("bub_out2", {24'd0, out_data}, 32'hE5);
        tick();
        chk("bub_out3_valid", {31'd0, out_valid}, 32'd1);
        chk("bub_out3", {24'd0, out_data}, 32'h58);
        tick();
        chk("bub_empty", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        drive8(1'b1, 8'hB1, 3'd3, 1'b1, 2'b00);
        tick();
        drive8(1'b1, 8'h96, 3'd2, 1'b1, 2'b01);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        tick();
        chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        drive8(1'b1, 8'h01, 3'd7, 1'b0, 2'b00);
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        chk("arst_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("arst_lat2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("arst_new_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_new_data", {24'd0, out_data}, 32'h80);

        // 32-bit instance: arithmetic right 31 then reserved mode
        w_in_valid = 1'b1; w_in_data = 32'h8000_0001; w_in_amt = 5'd31; w_in_dir = 1'b1; w_in_mode = 2'b10;
        tick();
        w_in_mode = 2'b11;
        chk("w_lat1", {31'd0, w_out_valid}, 32'd0);
        tick();
        w_in_valid = 1'b0;
        chk("w_lat2", {31'd0, w_out_valid}, 32'd0);
        tick();
        chk("w_lat3", {31'd0, w_out_valid}, 32'd0);
        tick();
        chk("w_lat4", {31'd0, w_out_valid}, 32'd0);
        tick();
        chk("w_asr_valid", {31'd0, w_out_valid}, 32'd1);
        chk("w_asr_data", w_out_data, 32'hFFFF_FFFF);
        tick();
        chk("w_rsv_valid", {31'd0, w_out_valid}, 32'd1);
        chk("w_rsv_data", w_out_data, 32'h0000_0003);
        tick();
        chk("w_done", {31'd0, w_out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
